// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the stage registers.
// Hazard/branch/memory requests in; hold/flush controls and status out.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_hold;
    logic             if_flush;
    logic             id_bubble;
    logic             back_hold;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hazard, branch_taken, mem_req, mem_ready,
        input  pc_hold, if_flush, id_bubble, back_hold,
        input  mem_err, stall_cnt
    );

    modport slave (
        input  hazard, branch_taken, mem_req, mem_ready,
        output pc_hold, if_flush, id_bubble, back_hold,
        output mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges hazard, branch and SRAM-wait stalls into
// per-stage hold/flush controls; owns the memory-wait FSM and stall counter.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic memstall;
    logic pc_hold, if_flush, id_bubble, back_hold;

    // Memory stall condition and prioritized stage controls
    always_comb begin
        memstall  = 1'b0;
        pc_hold   = 1'b0;
        if_flush  = 1'b0;
        id_bubble = 1'b0;
        back_hold = 1'b0;
        unique case (state_q)
            RUN:      memstall = bus.mem_req & ~bus.mem_ready;
            MEM_WAIT: memstall = ~bus.mem_ready;
            ERROR:    memstall = 1'b1;
            default:  memstall = 1'b0;
        endcase
        if (rst) begin
            pc_hold = 1'b0;
        end else if (memstall) begin
            pc_hold   = 1'b1;
            back_hold = 1'b1;
        end else if (bus.branch_taken) begin
            if_flush  = 1'b1;
            id_bubble = 1'b1;
        end else if (bus.hazard) begin
            pc_hold   = 1'b1;
            id_bubble = 1'b1;
        end
    end

    // Memory-wait FSM, timeout watchdog and saturating stall counter
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                    state_d   = ERROR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            ERROR: begin
                mem_err_d = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (pc_hold && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus.pc_hold   = pc_hold;
    assign bus.if_flush  = if_flush;
    assign bus.id_bubble = id_bubble;
    assign bus.back_hold = back_hold;
    assign bus.mem_err   = mem_err_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (TIMEOUT=8, CNT_W=4).
// Expected outputs are queued per step and checked before the next edge.
module tb_pipe_stall_ctrl;
    localparam int TO = 8;
    localparam int CW = 4;

    typedef struct {
        string    tag;
        logic     ph;
        logic     ifl;
        logic     idb;
        logic     bh;
        logic     err;
        int       cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t sb[$];

    pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_stall_ctrl #(
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic r, input logic h, input logic b,
                        input logic q, input logic y,
                        input logic ph, input logic ifl, input logic idb,
                        input logic bh, input logic err, input int cnt);
        exp_t e;
        @(negedge clk);
        rst              = r;
        bus.hazard       = h;
        bus.branch_taken = b;
        bus.mem_req      = q;
        bus.mem_ready    = y;
        e.tag = tag;
        e.ph  = ph;
        e.ifl = ifl;
        e.idb = idb;
        e.bh  = bh;
        e.err = err;
        e.cnt = cnt;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc_hold"},   int'(bus.pc_hold),   int'(e.ph));
        chk({e.tag, ".if_flush"},  int'(bus.if_flush),  int'(e.ifl));
        chk({e.tag, ".id_bubble"}, int'(bus.id_bubble), int'(e.idb));
        chk({e.tag, ".back_hold"}, int'(bus.back_hold), int'(e.bh));
        chk({e.tag, ".mem_err"},   int'(bus.mem_err),   int'(e.err));
        chk({e.tag, ".stall_cnt"}, int'(bus.stall_cnt), e.cnt);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst              = 1'b1;
        bus.hazard       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;

        // 1: reset then idle (hazard during reset is masked)
        step("rst0", 1,1,0,0,0, 0,0,0,0,0, 0);
        step("rst1", 1,0,1,1,0, 0,0,0,0,0, 0);
        step("idle", 0,0,0,0,0, 0,0,0,0,0, 0);

        // 2: hazard only
        step("haz",  0,1,0,0,0, 1,0,1,0,0, 0);
        step("haz+", 0,0,0,0,0, 0,0,0,0,0, 1);

        // 3: branch beats hazard
        step("brh",  0,1,1,0,0, 0,1,1,0,0, 1);
        step("brh+", 0,0,0,0,0, 0,0,0,0,0, 1);

        // 4: three wait cycles, hazard/branch ignored while frozen
        step("rst4", 1,0,0,0,0, 0,0,0,0,0, 1);
        step("mw0",  0,1,0,1,0, 1,0,0,1,0, 0);
        step("mw1",  0,1,1,1,0, 1,0,0,1,0, 1);
        step("mw2",  0,1,0,1,0, 1,0,0,1,0, 2);
        step("mrdy", 0,0,0,1,1, 0,0,0,0,0, 3);
        step("mw+",  0,0,0,0,0, 0,0,0,0,0, 3);
        step("zw",   0,0,0,1,1, 0,0,0,0,0, 3);
        step("spur", 0,0,0,0,1, 0,0,0,0,0, 3);
        step("spur+",0,0,0,0,0, 0,0,0,0,0, 3);

        // 5: timeout after 8 stall cycles, terminal until reset
        step("rst5", 1,0,0,0,0, 0,0,0,0,0, 3);
        for (int i = 0; i < TO; i++)
            step("to", 0,0,0,1,0, 1,0,0,1,0, i);
        step("err0", 0,0,0,1,1, 1,0,0,1,1, 8);
        step("err1", 0,1,1,0,1, 1,0,0,1,1, 9);
        step("errr", 1,0,0,0,0, 0,0,0,0,1, 10);
        step("err+", 0,0,0,0,0, 0,0,0,0,0, 0);

        // 6: saturation, then reset mid-wait
        for (int i = 0; i < 20; i++)
            step("sat", 0,1,0,0,0, 1,0,1,0,0, (i > 15) ? 15 : i);
        step("sat+", 0,0,0,0,0, 0,0,0,0,0, 15);
        for (int i = 0; i < 3; i++)
            step("mw6", 0,0,0,1,0, 1,0,0,1,0, 15);
        step("rst6", 1,0,0,1,0, 0,0,0,0,0, 15);
        step("rst6+",0,0,0,0,0, 0,0,0,0,0, 0);
        for (int i = 0; i < TO; i++)
            step("to6", 0,0,0,1,0, 1,0,0,1,0, i);
        step("to6e", 0,0,0,0,0, 1,0,0,1,1, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF, ID, EXE, MEM, WB).
- Combines three stall and flush sources into per-stage hold and flush controls:
  - the hazard detector's freeze,
  - the EXE-stage branch-taken flag,
  - the MEM-stage SRAM handshake.
- Owns the multi-cycle memory-wait FSM, a memory timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT, 64, max cycles in MEM_WAIT before declaring a memory error (≥2).
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard  input  1  freeze request from the hazard detection unit (RAW on src1/src2).
- branch_taken  input  1  EXE-stage instruction redirects the PC this cycle.
- mem_req  input  1  MEM-stage instruction is a load or store (MEM_R_EN | MEM_W_EN).
- mem_ready  input  1  SRAM controller completes the access this cycle.
- pc_hold  output  1  PC register and IF/ID hold their value.
- if_flush  output  1  IF/ID loads a NOP.
- id_bubble  output  1  ID/EX loads a NOP (WB_EN, MEM_R/W, branch cleared).
- back_hold  output  1  ID/EX, EXE/MEM and MEM/WB hold their value.
- mem_err  output  1  sticky memory-timeout flag.
- stall_cnt  output  CNT_W  saturating count of cycles with pc_hold=1.

Behaviour:
- Registered state:
  - state ∈ {RUN, MEM_WAIT, ERROR}
  - wait_cnt (log2(TIMEOUT)+1 bits)
  - stall_cnt
  - mem_err
- All control outputs are combinational from state and inputs. No added latency.
- Reset:
  - At a clk edge with rst=1: state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
  - While rst=1, the combinational outputs pc_hold, if_flush, id_bubble and back_hold are forced 0.
  - Reset mid-wait or in ERROR returns to RUN unconditionally.
- memstall:
  - Asserted when (state=RUN and mem_req and !mem_ready), or (state=MEM_WAIT and !mem_ready), or state=ERROR.
- Priority, evaluated each cycle:
  1. memstall → pc_hold=1, back_hold=1, if_flush=0, id_bubble=0. hazard and branch_taken are ignored. The stages are frozen, so they re-present afterwards.
  2. else branch_taken → if_flush=1, id_bubble=1, pc_hold=0, back_hold=0. The branch wins over hazard because the dependent instruction is squashed.
  3. else hazard → pc_hold=1, id_bubble=1, if_flush=0, back_hold=0.
  4. else all outputs 0.
- FSM:
  - RUN:
    - mem_req & !mem_ready → MEM_WAIT, wait_cnt←1.
    - mem_req & mem_ready (zero-wait access) → stay in RUN, no stall.
  - MEM_WAIT:
    - mem_ready → RUN, wait_cnt←0. The pipeline advances in this same cycle.
    - else if wait_cnt==TIMEOUT-1 → ERROR, mem_err←1.
    - else wait_cnt←wait_cnt+1.
  - ERROR:
    - Terminal until rst. Pipeline held (pc_hold=back_hold=1). mem_err=1.
- stall_cnt:
  - Increments at each edge where pc_hold=1 and rst=0.
  - Saturates at 2^CNT_W−1; it does not wrap.
- mem_ready with mem_req=0 in RUN is ignored (spurious). No state change.
- hazard and branch_taken may be asserted in any combination. Only the priority above applies.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles, then all inputs 0 → all outputs 0, stall_cnt=0, state RUN.
2. Hazard only: hazard=1 for 1 cycle → pc_hold=1, id_bubble=1, if_flush=0, back_hold=0; stall_cnt=1 after the edge.
3. Branch vs hazard: hazard=1 and branch_taken=1 in the same cycle → if_flush=1, id_bubble=1, pc_hold=0; stall_cnt unchanged.
4. Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high in cycle 4 → pc_hold=back_hold=1 for exactly 3 cycles, 0 in cycle 4, state back to RUN; hazard=1 during the wait produces no id_bubble; stall_cnt=3.
5. Timeout: TIMEOUT=8, mem_req=1, mem_ready never asserted → mem_err=1 after 8 stall cycles, outputs held; a later mem_ready=1 has no effect; rst=1 clears mem_err and returns to RUN.
6. Saturation and reset mid-wait: CNT_W=4, hazard held for 20 cycles → stall_cnt stops at 15. Then, in MEM_WAIT, rst=1 for 1 cycle → next cycle state RUN, stall_cnt=0, wait_cnt=0.
